// File: rtl/div_8bit_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master drives start and operands; the slave (the divider) returns status and results.
interface div_8bit_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_8bit_seq.sv
// Sequential restoring divider, unsigned: one quotient bit per clock using a WIDTH+1 bit trial
// subtraction, with a start/busy/done handshake and results held until the next completion.
module div_8bit_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    div_8bit_seq_if.slave   bus
);
    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [RW-1:0]    r, r_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH-1:0] d, d_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             dz, dz_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             dbz_q, dbz_n;
    logic [WIDTH-1:0] quot_q, quot_n;
    logic [WIDTH-1:0] rem_q, rem_n;

    logic [RW-1:0]    shifted;
    logic [RW-1:0]    trial;
    logic [RW-1:0]    r_step;
    logic [WIDTH-1:0] q_step;

    // One restoring step: shift {R,Q} left, trial-subtract D, keep the difference on no borrow.
    // R stays below D after every step, so dropping its top bit in the shift loses nothing.
    always_comb begin
        shifted = RW'({r, q[WIDTH-1]});
        trial   = shifted - {1'b0, d};
        if (!trial[WIDTH]) begin
            r_step = trial;
            q_step = {q[WIDTH-2:0], 1'b1};
        end else begin
            r_step = shifted;
            q_step = {q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_n = state;
        r_n     = r;
        q_n     = q;
        d_n     = d;
        cnt_n   = cnt;
        dz_n    = dz;
        busy_n  = busy_q;
        done_n  = 1'b0;
        dbz_n   = dbz_q;
        quot_n  = quot_q;
        rem_n   = rem_q;

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (bus.start) begin
                    q_n     = bus.dividend;
                    d_n     = bus.divisor;
                    r_n     = '0;
                    cnt_n   = CW'(WIDTH);
                    state_n = RUN;
                    // A zero divisor takes a single non-busy pass through RUN to report.
                    if (bus.divisor != '0) begin
                        dz_n   = 1'b0;
                        busy_n = 1'b1;
                        dbz_n  = 1'b0;
                    end else begin
                        dz_n   = 1'b1;
                        busy_n = 1'b0;
                    end
                end
            end

            RUN: begin
                if (dz) begin
                    dz_n    = 1'b0;
                    quot_n  = '1;
                    rem_n   = q;
                    dbz_n   = 1'b1;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    r_n   = r_step;
                    q_n   = q_step;
                    cnt_n = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        quot_n  = q_step;
                        rem_n   = r_step[WIDTH-1:0];
                        state_n = DONE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            r      <= '0;
            q      <= '0;
            d      <= '0;
            cnt    <= '0;
            dz     <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            state  <= state_n;
            r      <= r_n;
            q      <= q_n;
            d      <= d_n;
            cnt    <= cnt_n;
            dz     <= dz_n;
            busy_q <= busy_n;
            done_q <= done_n;
            dbz_q  <= dbz_n;
            quot_q <= quot_n;
            rem_q  <= rem_n;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_8bit_seq.sv
// Self-checking bench for div_8bit_seq: directed cases, handshake, back-to-back, reset abort
// and a randomized sweep against a plain-arithmetic reference.
module tb_div_8bit_seq;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned N_RAND  = 3000;
    localparam int          MAX_LAT = 20;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    div_8bit_seq_if #(.WIDTH(WIDTH)) bus ();

    div_8bit_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request for the next edge and follow it to done; caller is away from an edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] qo, output logic [7:0] ro, output logic dzo,
                         output int lat, output int busy_cnt);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat       = -1;
        busy_cnt  = 0;
        qo        = 'x;
        ro        = 'x;
        dzo       = 1'bx;
        if (bus.busy) busy_cnt++;
        for (int k = 1; k <= MAX_LAT && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                qo  = bus.quotient;
                ro  = bus.remainder;
                dzo = bus.div_by_zero;
            end else if (bus.busy) begin
                busy_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #3;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++;
        if (bus.quotient !== 8'd0) begin n_fail++; $display("FAIL reset_quot: got %0d expected 0", bus.quotient); end
        n_checks++;
        if (bus.remainder !== 8'd0) begin n_fail++; $display("FAIL reset_rem: got %0d expected 0", bus.remainder); end
        n_checks++;
        if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] ta [5] = '{8'd200, 8'd255, 8'd255, 8'd5, 8'd0};
        logic [7:0] tb [5] = '{8'd7,   8'd1,   8'd255, 8'd9, 8'd3};
        logic [7:0] eq [5] = '{8'd28,  8'd255, 8'd1,   8'd0, 8'd0};
        logic [7:0] er [5] = '{8'd4,   8'd0,   8'd0,   8'd5, 8'd0};
        logic [7:0] qo, ro;
        logic       dzo;
        int         lat, bc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            issue(ta[i], tb[i], qo, ro, dzo, lat, bc);
            n_checks++;
            if (lat !== 8) begin n_fail++; $display("FAIL basic_lat[%0d]: got %0d expected 8", i, lat); end
            n_checks++;
            if (bc !== 8) begin n_fail++; $display("FAIL basic_busy[%0d]: got %0d cycles expected 8", i, bc); end
            n_checks++;
            if (qo !== eq[i]) begin n_fail++; $display("FAIL basic_quot[%0d]: got %0d expected %0d", i, qo, eq[i]); end
            n_checks++;
            if (ro !== er[i]) begin n_fail++; $display("FAIL basic_rem[%0d]: got %0d expected %0d", i, ro, er[i]); end
            n_checks++;
            if (dzo !== 1'b0) begin n_fail++; $display("FAIL basic_dbz[%0d]: got %b expected 0", i, dzo); end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse[%0d]: got %b expected 0", i, bus.done); end
            n_checks++;
            if (bus.quotient !== eq[i]) begin n_fail++; $display("FAIL basic_hold[%0d]: got %0d expected %0d", i, bus.quotient, eq[i]); end
        end
    endtask

    task automatic test_div_by_zero();
        logic [7:0] qo, ro;
        logic       dzo;
        int         lat, bc;
        @(negedge clk);
        issue(8'd100, 8'd0, qo, ro, dzo, lat, bc);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL dbz_lat: got %0d expected 1", lat); end
        n_checks++;
        if (bc !== 0) begin n_fail++; $display("FAIL dbz_busy: got %0d cycles expected 0", bc); end
        n_checks++;
        if (qo !== 8'hFF) begin n_fail++; $display("FAIL dbz_quot: got %0d expected 255", qo); end
        n_checks++;
        if (ro !== 8'd100) begin n_fail++; $display("FAIL dbz_rem: got %0d expected 100", ro); end
        n_checks++;
        if (dzo !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", dzo); end
        @(negedge clk);
        issue(8'd10, 8'd3, qo, ro, dzo, lat, bc);
        n_checks++;
        if (qo !== 8'd3 || ro !== 8'd1) begin n_fail++; $display("FAIL dbz_next: got %0d r %0d expected 3 r 1", qo, ro); end
        n_checks++;
        if (dzo !== 1'b0) begin n_fail++; $display("FAIL dbz_cleared: got %b expected 0", dzo); end
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("FAIL dbz_next_lat: got %0d expected 8", lat); end
    endtask

    task automatic test_handshake();
        int         lat, dones;
        logic [7:0] qo, ro;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd76;
        bus.divisor  = 8'd21;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat   = -1;
        dones = 0;
        qo    = 'x;
        ro    = 'x;
        for (int k = 1; k <= 15; k++) begin
            if (k == 3) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd49;
                bus.divisor  = 8'd24;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = k;
                    qo  = bus.quotient;
                    ro  = bus.remainder;
                end
            end
        end
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("FAIL hs_pulses: got %0d expected 1", dones); end
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("FAIL hs_lat: got %0d expected 8", lat); end
        n_checks++;
        if (qo !== 8'd3 || ro !== 8'd13) begin n_fail++; $display("FAIL hs_result: got %0d r %0d expected 3 r 13", qo, ro); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] qo, ro;
        logic       dzo;
        int         lat, bc;
        @(negedge clk);
        issue(8'd97, 8'd33, qo, ro, dzo, lat, bc);
        n_checks++;
        if (qo !== 8'd2 || ro !== 8'd31) begin n_fail++; $display("FAIL b2b_first: got %0d r %0d expected 2 r 31", qo, ro); end
        // Still inside the done cycle: the next edge must accept the new request.
        issue(8'd113, 8'd57, qo, ro, dzo, lat, bc);
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("FAIL b2b_lat: got %0d expected 8", lat); end
        n_checks++;
        if (qo !== 8'd1 || ro !== 8'd56) begin n_fail++; $display("FAIL b2b_second: got %0d r %0d expected 1 r 56", qo, ro); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] qo, ro;
        logic       dzo;
        int         lat, bc, dones;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_flags: got busy %b done %b dbz %b expected 0 0 0", bus.busy, bus.done, bus.div_by_zero); end
        n_checks++;
        if (bus.quotient !== 8'd0 || bus.remainder !== 8'd0)
            begin n_fail++; $display("FAIL rstmid_result: got %0d r %0d expected 0 r 0", bus.quotient, bus.remainder); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dones++;
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", dones); end
        @(negedge clk);
        issue(8'd14, 8'd7, qo, ro, dzo, lat, bc);
        n_checks++;
        if (qo !== 8'd2 || ro !== 8'd0 || lat !== 8)
            begin n_fail++; $display("FAIL rstmid_after: got %0d r %0d lat %0d expected 2 r 0 lat 8", qo, ro, lat); end
    endtask

    task automatic test_random();
        logic [7:0] a, b, qo, ro, eq, er;
        logic       dzo;
        int         lat, bc;
        for (int i = 0; i < N_RAND; i++) begin
            a = 8'($urandom);
            b = 8'($urandom_range(255, 1));
            eq = a / b;
            er = a % b;
            @(negedge clk);
            issue(a, b, qo, ro, dzo, lat, bc);
            n_checks++;
            if (qo !== eq || ro !== er || dzo !== 1'b0 || lat !== 8) begin
                n_fail++;
                $display("FAIL rand_model %0d/%0d: got %0d r %0d dbz %b lat %0d expected %0d r %0d dbz 0 lat 8",
                         a, b, qo, ro, dzo, lat, eq, er);
            end
            n_checks++;
            if ((16'(qo) * 16'(b) + 16'(ro)) !== 16'(a) || !(ro < b)) begin
                n_fail++;
                $display("FAIL rand_invariant %0d/%0d: got q %0d r %0d", a, b, qo, ro);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_div_by_zero();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
